// File: rtl/song_out_ctrl.sv
// song_out_ctrl: selects one tone generator, mutes it outside PLAY, drives the buzzer pin.
// Latency: source pin to beep is 3 clk (2 sync flops + output register); keys add debounce time.
// No backpressure: free-running output stage. Optional macro BEEP_PWM_EN adds volume PWM on beep.
module song_out_ctrl #(
   parameter int unsigned DB_CYCLES  = 1000000,
   parameter int unsigned GAP_CYCLES = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_play,
   input  logic       piano_beep,
   input  logic       song1_beep,
   input  logic       song2_beep,
   input  logic       song3_beep,
`ifdef BEEP_PWM_EN
   input  logic [2:0] volume,
`endif
   output logic       beep,
   output logic [1:0] mode,
   output logic       playing
);

   localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
   localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
   localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_PAUSE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // bit 0 key_mode, bit 1 key_play, bits 2..5 piano/song1/song2/song3
   logic [5:0] raw_in;
   logic [5:0] sync1_q, sync2_q;

   logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]          key_acc_q, key_acc_d;
   logic [1:0]          key_press;

   state_e         state_q, state_d;
   logic [1:0]     mode_q, mode_d;
   logic           resume_q, resume_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic           playing_q, playing_d;
   logic           beep_q, beep_d;
   logic           src_sel;
   logic           mode_press, play_press;

`ifdef BEEP_PWM_EN
   logic [2:0] pwm_cnt_q;
`endif

   assign raw_in = {song3_beep, song2_beep, song1_beep, piano_beep, key_play, key_mode};

   // Two-flop synchronisers for every asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: a key level is accepted only after DB_CYCLES consecutive differing samples.
   always_comb begin
      db_cnt_d  = db_cnt_q;
      key_acc_d = key_acc_q;
      key_press = '0;
      for (int k = 0; k < 2; k++) begin
         if (sync2_q[k] == key_acc_q[k]) begin
            db_cnt_d[k] = '0;
         end else if (db_cnt_q[k] == DB_LAST) begin
            db_cnt_d[k]  = '0;
            key_acc_d[k] = sync2_q[k];
            key_press[k] = sync2_q[k];
         end else begin
            db_cnt_d[k] = db_cnt_q[k] + DBW'(1);
         end
      end
   end

   // Debounce counters and accepted key levels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_q  <= '0;
         key_acc_q <= '0;
      end else begin
         db_cnt_q  <= db_cnt_d;
         key_acc_q <= key_acc_d;
      end
   end

   assign mode_press = key_press[0];
   assign play_press = key_press[1];

   // Next-state logic; a mode press always beats a play press in the same cycle.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      resume_d = resume_q;
      gap_d    = gap_q;
      unique case (state_q)
         ST_PAUSE: begin
            if (mode_press) begin
               mode_d   = mode_q + 2'd1;
               resume_d = 1'b0;
               gap_d    = '0;
               state_d  = ST_GAP;
            end else if (play_press) begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (mode_press) begin
               mode_d   = mode_q + 2'd1;
               resume_d = 1'b1;
               gap_d    = '0;
               state_d  = ST_GAP;
            end else if (play_press) begin
               state_d = ST_PAUSE;
            end
         end
         ST_GAP: begin
            if (mode_press) begin
               mode_d = mode_q + 2'd1;
               gap_d  = '0;
            end else if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = resume_q ? ST_PLAY : ST_PAUSE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = ST_PAUSE;
         end
      endcase
      playing_d = (state_d == ST_PLAY);
   end

   // Source mux and mute; muting follows the registered state so beep drops one edge after leaving PLAY.
   always_comb begin
      src_sel = sync2_q[2 + {30'd0, mode_q}];
      beep_d  = (state_q == ST_PLAY) && src_sel;
`ifdef BEEP_PWM_EN
      beep_d  = beep_d && (pwm_cnt_q < volume);
`endif
   end

   // State, mode, gap timer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_PAUSE;
         mode_q    <= 2'd0;
         resume_q  <= 1'b0;
         gap_q     <= '0;
         playing_q <= 1'b0;
         beep_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         resume_q  <= resume_d;
         gap_q     <= gap_d;
         playing_q <= playing_d;
         beep_q    <= beep_d;
      end
   end

`ifdef BEEP_PWM_EN
   // Free-running PWM phase counter for volume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= 3'd0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 3'd1;
      end
   end
`endif

   assign beep    = beep_q;
   assign mode    = mode_q;
   assign playing = playing_q;

endmodule

// File: tb/tb_song_out_ctrl.sv
// tb_song_out_ctrl: directed scenarios plus random key activity against a behavioural model.
// Sources toggle with half-periods 6/8/10/12 clk; keys bounce randomly before settling.
// Define BEEP_PWM_EN to also exercise the volume input.
module tb_song_out_ctrl;
   localparam int DB  = 4;
   localparam int GAP = 10;
   localparam int M_PAUSE = 0, M_PLAY = 1, M_GAP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_mode = 1'b0, key_play = 1'b0;
   logic       piano_beep = 1'b0, song1_beep = 1'b0, song2_beep = 1'b0, song3_beep = 1'b0;
   logic       beep;
   logic [1:0] mode;
   logic       playing;
`ifdef BEEP_PWM_EN
   logic [2:0] volume = 3'd7;
`endif

   int n_cmp = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   song_out_ctrl #(.DB_CYCLES(DB), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_mode   (key_mode),
      .key_play   (key_play),
      .piano_beep (piano_beep),
      .song1_beep (song1_beep),
      .song2_beep (song2_beep),
      .song3_beep (song3_beep),
`ifdef BEEP_PWM_EN
      .volume     (volume),
`endif
      .beep       (beep),
      .mode       (mode),
      .playing    (playing)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Tone sources: independent square waves, never reset.
   initial begin
      int cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc % 6 == 0)  piano_beep = ~piano_beep;
         if (cyc % 8 == 0)  song1_beep = ~song1_beep;
         if (cyc % 10 == 0) song2_beep = ~song2_beep;
         if (cyc % 12 == 0) song3_beep = ~song3_beep;
      end
   end

   // Behavioural reference: pins seen two edges late, keys accepted after DB steady samples,
   // state/mode per the play/pause/gap rules, beep = delayed source gated by pre-edge state.
   int       m_state, m_mode, m_rem, m_pwm;
   bit       m_resume, m_beep;
   bit [5:0] h1, h2, raw, s;
   bit [1:0] acc, pr;
   int       run [2];
   bit       nb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = M_PAUSE; m_mode = 0; m_rem = 0; m_pwm = 0;
         m_resume = 0; m_beep = 0; h1 = '0; h2 = '0; acc = '0;
         run[0] = 0; run[1] = 0;
      end else begin
         raw = {song3_beep, song2_beep, song1_beep, piano_beep, key_play, key_mode};
         s   = h2;
         pr  = '0;
         for (int k = 0; k < 2; k++) begin
            if (s[k] != acc[k]) begin
               run[k]++;
               if (run[k] == DB) begin
                  acc[k] = s[k];
                  run[k] = 0;
                  pr[k]  = s[k];
               end
            end else begin
               run[k] = 0;
            end
         end
         nb = (m_state == M_PLAY) && s[2 + m_mode];
`ifdef BEEP_PWM_EN
         nb = nb && (m_pwm < int'(volume));
`endif
         m_pwm = (m_pwm + 1) % 8;
         if (pr[0]) begin
            if (m_state != M_GAP) m_resume = (m_state == M_PLAY);
            m_mode  = (m_mode + 1) % 4;
            m_state = M_GAP;
            m_rem   = GAP;
         end else if (m_state == M_GAP) begin
            m_rem--;
            if (m_rem == 0) m_state = m_resume ? M_PLAY : M_PAUSE;
         end else if (pr[1]) begin
            m_state = (m_state == M_PLAY) ? M_PAUSE : M_PLAY;
         end
         m_beep = nb;
         h2 = h1;
         h1 = raw;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         check_val("beep", int'(beep), int'(m_beep));
         check_val("mode", int'(mode), m_mode);
         check_val("playing", int'(playing), int'(m_state == M_PLAY));
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bouncy press: random chatter, steady high, chatter, steady low.
   task automatic press(input bit m, input bit p, input int bounce, input int hold, input int idle);
      bit b;
      repeat (bounce) begin
         @(negedge clk);
         b = 1'($urandom);
         if (m) key_mode = b;
         if (p) key_play = b;
      end
      @(negedge clk);
      if (m) key_mode = 1'b1;
      if (p) key_play = 1'b1;
      wait_cyc(hold);
      repeat (bounce) begin
         @(negedge clk);
         b = 1'($urandom);
         if (m) key_mode = b;
         if (p) key_play = b;
      end
      @(negedge clk);
      key_mode = 1'b0;
      key_play = 1'b0;
      wait_cyc(idle);
   endtask

   // Clean pulse: high for hi cycles, then low for lo cycles.
   task automatic pulse(input bit m, input bit p, input int hi, input int lo);
      @(negedge clk);
      if (m) key_mode = 1'b1;
      if (p) key_play = 1'b1;
      wait_cyc(hi);
      key_mode = 1'b0;
      key_play = 1'b0;
      wait_cyc(lo);
   endtask

   initial begin
      int highs;
      bit hit;
      wait_cyc(3);
      rst_n = 1'b1;
      chk_on = 1'b1;

      // Idle after reset: everything stays quiet.
      wait_cyc(50);
      check_val("idle_beep", int'(beep), 0);
      check_val("idle_mode", int'(mode), 0);
      check_val("idle_playing", int'(playing), 0);

      // Bouncy play press starts playback of piano.
      press(1'b0, 1'b1, 3, 10, 12);
      check_val("play_on", int'(playing), 1);
      check_val("play_mode", int'(mode), 0);
      wait_cyc(30);
      check_val("play_still_on", int'(playing), 1);

      // Mode press while playing: mode 1, silent gap, then resume.
      pulse(1'b1, 1'b0, 8, 0);
      check_val("gap_mode1", int'(mode), 1);
      check_val("gap_muted", int'(playing), 0);
      key_mode = 1'b0;
      wait_cyc(20);
      check_val("resume_after_gap", int'(playing), 1);
      wait_cyc(30);

      // Two presses 8 cycles apart: second lands inside the gap and restarts it.
      pulse(1'b1, 1'b0, DB, DB);
      pulse(1'b1, 1'b0, DB, 2);
      check_val("gap_restart_mode", int'(mode), 3);
      check_val("gap_restart_muted", int'(playing), 0);
      wait_cyc(4);
      check_val("gap_restart_still_muted", int'(playing), 0);
      wait_cyc(20);
      check_val("gap_restart_resume", int'(playing), 1);

      // Fourth mode press wraps back to piano.
      press(1'b1, 1'b0, 2, 10, 20);
      check_val("mode_wrap", int'(mode), 0);
      check_val("wrap_resume", int'(playing), 1);

      // Pause, then simultaneous mode+play: mode wins, stays paused after the gap.
      press(1'b0, 1'b1, 2, 10, 12);
      check_val("paused", int'(playing), 0);
      pulse(1'b1, 1'b1, 8, 20);
      check_val("simul_mode", int'(mode), 1);
      check_val("simul_paused", int'(playing), 0);
      check_val("simul_beep", int'(beep), 0);

      // Random key activity.
      for (int i = 0; i < 40; i++) begin
         int sel;
         sel = int'($urandom_range(0, 3));
         press(sel == 0 || sel == 2, sel != 0, int'($urandom_range(0, 3)),
               int'($urandom_range(6, 20)), int'($urandom_range(6, 30)));
      end

      // Step the mode to 3 and reset in the middle of the gap.
      hit = 1'b0;
      for (int i = 0; i < 8 && !hit; i++) begin
         pulse(1'b1, 1'b0, 7, 0);
         if (m_mode == 3 && m_state == M_GAP) hit = 1'b1;
         else begin
            key_mode = 1'b0;
            wait_cyc(20);
         end
      end
      check_val("reach_mode3", int'(hit), 1);
      wait_cyc(2);
      check_val("pre_reset_mode", int'(mode), 3);
      check_val("pre_reset_playing", int'(playing), 0);
      key_mode = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_beep", int'(beep), 0);
      check_val("rst_mode", int'(mode), 0);
      check_val("rst_playing", int'(playing), 0);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(10);
      check_val("post_rst_mode", int'(mode), 0);

`ifdef BEEP_PWM_EN
      // Volume 0 is silent even while playing.
      volume = 3'd0;
      press(1'b0, 1'b1, 1, 10, 10);
      highs = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         highs += int'(beep);
      end
      check_val("vol0_highs", highs, 0);
      // Volume 4: model checks the 4-of-8 duty every cycle.
      volume = 3'd4;
      wait_cyc(64);
`else
      highs = 0;
      press(1'b0, 1'b1, 1, 10, 40);
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         highs += int'(beep);
      end
      check_val("play_has_sound", int'(highs > 0), 1);
`endif

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
